// File: rtl/mem_line_requester_pkg.sv
// Shared constants and FSM encoding for the cache-line memory requester.
// The line geometry helpers let each user derive its own widths from LINE_WORDS.
package mem_line_requester_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_TIMEOUT    = 64;
    localparam int LINE_BYTES     = DEF_LINE_WORDS * WORD_BYTES;
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic int line_bytes(input int line_words);
        return line_words * WORD_BYTES;
    endfunction

    function automatic int offset_bits(input int line_words);
        return $clog2(line_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_line_requester_if.sv
// Cache-side request/response and memory-side request/done signals of the line requester.
// master is the requester's view; slave is the view of the cache plus memory around it.
interface mem_line_requester_if
    import mem_line_requester_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS
);

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wr;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [32*LINE_WORDS-1:0]  req_wdata;

    logic                      resp_valid;
    logic                      resp_err;
    logic [32*LINE_WORDS-1:0]  resp_rdata;

    logic                      mem_en;
    logic                      mem_re;
    logic                      mem_wr;
    logic [ADDR_WIDTH-1:0]     mem_address;
    logic [31:0]               mem_data_in;
    logic [31:0]               mem_data_out;
    logic                      mem_done;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_err, resp_rdata,
        output mem_en, mem_re, mem_wr, mem_address, mem_data_in,
        input  mem_data_out, mem_done
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_err, resp_rdata,
        input  mem_en, mem_re, mem_wr, mem_address, mem_data_in,
        output mem_data_out, mem_done
    );

endinterface

// File: rtl/mem_line_requester.sv
// Splits one cache-line fill or writeback into LINE_WORDS sequential word
// transactions on the request/done memory port and returns the assembled line.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a line request
// ISSUE | one-cycle mem_en strobe for word idx
// WAIT  | waiting for mem_done of word idx, wait counter running
// RESP  | one-cycle resp_valid with resp_err
module mem_line_requester
    import mem_line_requester_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_line_requester_if.master bus
);

    localparam int DATA_W   = 32 * LINE_WORDS;
    localparam int IDX_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS = offset_bits(LINE_WORDS);
    localparam int CNT_BITS = $clog2(TIMEOUT);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LINE_WORDS - 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            data_in_q, data_in_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [CNT_BITS-1:0]    wait_q, wait_d;

    function automatic logic [31:0] pick_word(input logic [DATA_W-1:0] line,
                                              input logic [IDX_BITS-1:0] i);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (IDX_BITS'(k) == i) begin
                w = line[k*32 +: 32];
            end
        end
        return w;
    endfunction

    // base is line aligned, so OR-ing in the word offset equals base + 4*idx
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [IDX_BITS-1:0]   i);
        return base | (ADDR_WIDTH'(i) << 2);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            base_q    <= '0;
            addr_q    <= '0;
            data_in_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            data_in_q <= data_in_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        err_d     = err_q;
        base_d    = base_q;
        addr_d    = addr_q;
        data_in_d = data_in_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        wait_d    = wait_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d      = bus.req_wr;
                    wdata_d   = bus.req_wdata;
                    base_d    = {bus.req_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
                    idx_d     = '0;
                    err_d     = 1'b0;
                    addr_d    = {bus.req_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
                    data_in_d = bus.req_wr ? pick_word(bus.req_wdata, '0) : 32'h0;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.mem_done) begin
                    if (!wr_q) begin
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            if (IDX_BITS'(k) == idx_q) begin
                                rdata_d[k*32 +: 32] = bus.mem_data_out;
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        addr_d    = word_addr(base_q, idx_d);
                        data_in_d = wr_q ? pick_word(wdata_q, idx_d) : 32'h0;
                        state_d   = ST_ISSUE;
                    end
                end else if (wait_q == LAST_CNT) begin
                    // unread words keep whatever the previous line left there
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_err    = err_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.mem_en      = (state_q == ST_ISSUE);
    assign bus.mem_re      = (state_q == ST_ISSUE) && !wr_q;
    assign bus.mem_wr      = (state_q == ST_ISSUE) && wr_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = data_in_q;

endmodule

// File: tb/tb_mem_line_requester.sv
// Scoreboard bench for mem_line_requester with a behavioural latency-L memory responder.
// Expected issues and responses are queued by the stimulus and checked by a negedge monitor.
module tb_mem_line_requester;
    import mem_line_requester_pkg::*;

    localparam int AW = 20;
    localparam int LW = 4;
    localparam int TO = 64;
    localparam int DW = 32 * LW;

    localparam logic [DW-1:0] L100 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [DW-1:0] L200 = {32'hFFFFFFFF, 32'h00000000, 32'hCAFEF00D, 32'hDEADBEEF};
    localparam logic [DW-1:0] L300 = {32'h89ABCDEF, 32'h01234567, 32'h5A5A5A5A, 32'hA5A5A5A5};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_line_requester_if #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus ();

    mem_line_requester #(.ADDR_WIDTH(AW), .LINE_WORDS(LW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory responder: accepts at the end of ISSUE, done visible L+2 cycles later
    logic [31:0] mem_arr [0:1023];
    logic        mdl_busy;
    int          mdl_cnt;
    logic [31:0] mdl_rdata;
    int          mem_lat;
    bit          mem_mute;
    bit          done_force;
    logic        bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem_arr[bd_addr[11:2]] <= bd_data;
        else if (bus.mem_en && bus.mem_wr) mem_arr[bus.mem_address[11:2]] <= bus.mem_data_in;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy  <= 1'b0;
            mdl_cnt   <= 0;
            mdl_rdata <= '0;
        end else if (bus.mem_en) begin
            mdl_busy  <= 1'b1;
            mdl_cnt   <= mem_lat + 2;
            mdl_rdata <= mem_arr[bus.mem_address[11:2]];
        end else if (mdl_busy) begin
            if (mdl_cnt == 1) mdl_busy <= 1'b0;
            else mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign bus.mem_done     = (mdl_busy && mdl_cnt == 1 && !mem_mute) || done_force;
    assign bus.mem_data_out = mdl_rdata;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   data;
        int            gap;
        int            from_resp;
    } issue_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } resp_t;

    issue_t exp_issue[$];
    resp_t  exp_resp[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor
    int     cyc = 0;
    int     first_issue = 0;
    int     last_issue = 0;
    int     last_resp = 0;
    int     issues_seen = 0;
    bit     txn_active = 0;
    bit     ready_bad = 0;
    bit     chk_ready_next = 0;
    issue_t mi;
    resp_t  mr;

    always @(negedge clk) begin
        if (rst) begin
            txn_active     = 0;
            chk_ready_next = 0;
        end else begin
            cyc++;
            if (chk_ready_next) begin
                chk("ready_after_resp", DW'(bus.req_ready), DW'(1));
                chk_ready_next = 0;
            end
            if (bus.mem_en) begin
                issues_seen++;
                if (!txn_active) begin
                    txn_active  = 1;
                    first_issue = cyc;
                    ready_bad   = 0;
                end
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", DW'(bus.mem_en), DW'(0));
                end else begin
                    mi = exp_issue.pop_front();
                    chk("issue_addr", DW'(bus.mem_address), DW'(mi.addr));
                    chk("issue_wr", DW'(bus.mem_wr), DW'(mi.wr));
                    chk("issue_re", DW'(bus.mem_re), DW'(!mi.wr));
                    chk("issue_data_in", DW'(bus.mem_data_in), DW'(mi.data));
                    if (mi.gap >= 0) chk("issue_spacing", DW'(cyc - last_issue), DW'(mi.gap));
                    if (mi.from_resp >= 0) chk("accept_after_resp", DW'(cyc - last_resp), DW'(mi.from_resp));
                end
                last_issue = cyc;
            end
            if (txn_active && bus.req_ready) ready_bad = 1;
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", DW'(bus.resp_valid), DW'(0));
                end else begin
                    mr = exp_resp.pop_front();
                    chk("resp_err", DW'(bus.resp_err), DW'(mr.err));
                    chk("resp_rdata", bus.resp_rdata, mr.rdata);
                    chk("resp_latency", DW'(cyc - first_issue), DW'(mr.lat));
                    chk("ready_low_while_busy", DW'(ready_bad), DW'(0));
                end
                txn_active     = 0;
                last_resp      = cyc;
                chk_ready_next = 1;
            end
        end
    end

    task automatic push_line(input logic wr, input logic [AW-1:0] base, input logic [DW-1:0] wd,
                             input int lat, input int first_from_resp, input int nwords);
        issue_t e;
        for (int i = 0; i < nwords; i++) begin
            e.addr      = base + AW'(4 * i);
            e.wr        = wr;
            e.data      = wr ? wd[i*32 +: 32] : 32'h0;
            e.gap       = (i == 0) ? -1 : lat + 3;
            e.from_resp = (i == 0) ? first_from_resp : -1;
            exp_issue.push_back(e);
        end
    endtask

    task automatic push_resp(input logic err, input logic [DW-1:0] rd, input int lat);
        resp_t r;
        r.err   = err;
        r.rdata = rd;
        r.lat   = lat;
        exp_resp.push_back(r);
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    task automatic req_send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
        int n;
        n = 0;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_accept_timeout", DW'(bus.req_ready), DW'(1));
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_issue.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", DW'(exp_resp.size() + exp_issue.size()), DW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int seen0;
        int n;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        done_force    = 0;
        mem_mute      = 0;
        mem_lat       = 10;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_data       = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
        chk("rst_resp_valid", DW'(bus.resp_valid), DW'(0));
        chk("rst_mem_en", DW'(bus.mem_en), DW'(0));
        chk("rst_mem_address", DW'(bus.mem_address), DW'(0));
        chk("rst_resp_rdata", bus.resp_rdata, '0);

        for (int i = 0; i < LW; i++) bd_write(AW'(20'h100 + 4 * i), L100[i*32 +: 32]);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // fill L=10 from an unaligned address inside the line
        push_line(1'b0, 20'h100, '0, 10, -1, LW);
        push_resp(1'b0, L100, 52);
        req_send(1'b0, 20'h104, '0, 0);
        wait_drain(400);

        // writeback then fill the same line
        push_line(1'b1, 20'h200, L200, 10, -1, LW);
        push_resp(1'b0, L100, 52);
        req_send(1'b1, 20'h200, L200, 0);
        wait_drain(400);
        push_line(1'b0, 20'h200, '0, 10, -1, LW);
        push_resp(1'b0, L200, 52);
        req_send(1'b0, 20'h200, '0, 0);
        wait_drain(400);

        // stale done in IDLE, then in the ISSUE cycle of word 0
        done_force = 1;
        repeat (3) @(posedge clk);
        #1;
        done_force = 0;
        chk("stale_idle_ready", DW'(bus.req_ready), DW'(1));
        chk("stale_idle_rdata", bus.resp_rdata, L200);
        push_line(1'b0, 20'h100, '0, 10, -1, LW);
        push_resp(1'b0, L100, 52);
        req_send(1'b0, 20'h10F, '0, 0);
        done_force = 1;
        @(posedge clk);
        #1;
        done_force = 0;
        wait_drain(400);

        // timeout: memory never answers
        mem_mute = 1;
        push_line(1'b0, 20'h300, '0, 10, -1, 1);
        push_resp(1'b1, L100, TO + 1);
        req_send(1'b0, 20'h300, '0, 0);
        wait_drain(400);
        repeat (15) @(posedge clk);
        #1;
        mem_mute = 0;

        // reset while waiting on word 2
        push_line(1'b0, 20'h200, '0, 10, -1, 3);
        seen0 = issues_seen;
        req_send(1'b0, 20'h200, '0, 0);
        n = 0;
        while (issues_seen < seen0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midop_issue_count", DW'(issues_seen - seen0), DW'(3));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midop_mem_en", DW'(bus.mem_en), DW'(0));
        chk("midop_mem_re", DW'(bus.mem_re), DW'(0));
        chk("midop_mem_wr", DW'(bus.mem_wr), DW'(0));
        chk("midop_mem_address", DW'(bus.mem_address), DW'(0));
        chk("midop_mem_data_in", DW'(bus.mem_data_in), DW'(0));
        chk("midop_resp_valid", DW'(bus.resp_valid), DW'(0));
        chk("midop_req_ready", DW'(bus.req_ready), DW'(1));
        chk("midop_resp_rdata", bus.resp_rdata, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_lat = 3;
        @(posedge clk);
        #1;
        push_line(1'b0, 20'h100, '0, 3, -1, LW);
        push_resp(1'b0, L100, 24);
        req_send(1'b0, 20'h100, '0, 0);
        wait_drain(400);

        // back-to-back with req_valid held high, L=2
        mem_lat = 2;
        push_line(1'b1, 20'h300, L300, 2, -1, LW);
        push_resp(1'b0, L100, 20);
        push_line(1'b0, 20'h300, '0, 2, 2, LW);
        push_resp(1'b0, L300, 20);
        req_send(1'b1, 20'h300, L300, 1);
        req_send(1'b0, 20'h308, '0, 0);
        wait_drain(400);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
